// File: rtl/cone_eval_arbiter_pkg.sv
// Shared types and defaults for the cone-evaluator arbiter and its round-robin helper.
package cone_eval_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int NREQ_DEF     = 4;
   localparam int SW_DEF       = 16;
   localparam int EVAL_LAT_DEF = 2;

   // Smallest r with 2**r >= v; used to validate the requester-ID width.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/cone_eval_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or above rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   int  idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(rr_ptr) + off) % NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/cone_eval_arbiter.sv
// Time-shares one combinational cone evaluator among NREQ requesters with a tagged response.
// Optional CONE_EVAL_PARITY_EN adds rsp_par and a sticky par_err settle-stability flag.
module cone_eval_arbiter
   import cone_eval_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int SW       = SW_DEF,
   parameter int EVAL_LAT = EVAL_LAT_DEF,
   parameter int IDW      = 2
) (
   input  logic               CK,
   input  logic               RST,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*SW-1:0] req_state,
   input  logic [NREQ-1:0]    req_en,
   output logic [SW-1:0]      ev_state,
   input  logic [SW-1:0]      ev_next,
   output logic               ev_busy,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [SW-1:0]      rsp_next
`ifdef CONE_EVAL_PARITY_EN
   ,
   output logic               rsp_par,
   output logic               par_err
`endif
);

   if (IDW < clog2(NREQ) || NREQ < 2 || NREQ > 8 || EVAL_LAT < 1 || EVAL_LAT > 15) begin : g_bad_cfg
      $error("cone_eval_arbiter: unsupported parameter combination");
   end

   state_t          state, next_state;
   logic [3:0]      cnt;
   logic [IDW-1:0]  rr_ptr, g_reg, grant_idx;
   logic [NREQ-1:0] grant;
   logic [SW-1:0]   sel_state;
   logic            any_req, load_bypass, load_eval;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign any_req     = |req_valid;
   assign sel_state   = req_state[grant_idx*SW +: SW];
   assign load_bypass = (state == IDLE) && any_req && !req_en[grant_idx];
   assign load_eval   = (state == EVAL) && (cnt == 4'd0);

   always_ff @(posedge CK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // Grant is offered only from IDLE and never while reset is asserted.
   always_comb begin
      next_state = state;
      req_ready  = '0;
      case (state)
         IDLE: if (any_req) begin
            req_ready  = grant;
            next_state = req_en[grant_idx] ? EVAL : RESP;
         end
         EVAL: if (cnt == 4'd0) next_state = RESP;
         RESP: if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (RST) req_ready = '0;
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         rr_ptr    <= '0;
         g_reg     <= '0;
         cnt       <= '0;
         ev_state  <= '0;
         ev_busy   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_next  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               ev_state <= sel_state;
               g_reg    <= grant_idx;
               if (req_en[grant_idx]) begin
                  cnt     <= 4'(EVAL_LAT - 1);
                  ev_busy <= 1'b1;
               end else begin
                  rsp_next  <= sel_state;
                  rsp_id    <= grant_idx;
                  rsp_valid <= 1'b1;
               end
            end
            EVAL: if (load_eval) begin
               rsp_next  <= ev_next;
               rsp_id    <= g_reg;
               rsp_valid <= 1'b1;
               ev_busy   <= 1'b0;
            end else begin
               cnt <= cnt - 4'd1;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rr_ptr    <= (g_reg == IDW'(NREQ - 1)) ? '0 : g_reg + IDW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CONE_EVAL_PARITY_EN
   logic [SW-1:0] ev_prev;
   logic          prev_ok;

   // ev_prev is only meaningful when the previous cycle was also an EVAL cycle.
   always_ff @(posedge CK) begin
      if (RST) begin
         rsp_par <= 1'b0;
         par_err <= 1'b0;
         ev_prev <= '0;
         prev_ok <= 1'b0;
      end else begin
         ev_prev <= ev_next;
         prev_ok <= (state == EVAL);
         if (load_bypass)    rsp_par <= ^sel_state;
         else if (load_eval) rsp_par <= ^ev_next;
         if (load_eval && prev_ok && (ev_next != ev_prev)) par_err <= 1'b1;
      end
   end
`endif

endmodule
